shift_reg_ctrl: RTL

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

---
 rtl/shift_reg_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//
// Sequences an external N-bit shift register so that a word offered on a
// valid/ready handshake is presented on the register's serial output, one bit
// per cycle, LSB first.
// Each frame runs:
//   IDLE  -> accept and hold a word
//   LOAD  -> parallel-load the held word
//   SHIFT -> N un-stalled shift cycles; stall pauses the register
//   DONE  -> one-cycle end-of-frame pulse
//
// Optional build macro SHIFT_REG_CTRL_PARITY_EN inserts a PARITY state
// between SHIFT and DONE. That state presents the XOR of the held word on
// parity_bit for one cycle. Without the macro, the parity outputs are tied
// to 0.
//
// Reset is asynchronous and active-high. While rst is high every output,
// in_ready included, is forced to 0.
// -----------------------------------------------------------------------------
module shift_reg_ctrl #(
   parameter int   N    = 4,
   parameter logic FILL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [N-1:0]         in_data,
   output logic                 in_ready,
   input  logic                 stall,
   output logic                 sr_load_enable,
   output logic                 sr_serial_parallel,
   output logic [N-1:0]         sr_parallel_in,
   output logic                 sr_serial_in,
   output logic                 bit_valid,
   output logic [$clog2(N)-1:0] bit_idx,
   output logic                 parity_valid,
   output logic                 parity_bit,
   output logic                 busy,
   output logic                 done
);

   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
`ifdef SHIFT_REG_CTRL_PARITY_EN
      PARITY,
`endif
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [N-1:0]  hold_q,  hold_d;

   // State, bit counter and held word registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every register samples the pre-edge values regardless of block
      // ordering.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         // NOTE: the holding register is data, not control, but it is
         // reset anyway. This keeps parallel_in and parity defined before
         // the first word arrives.
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic and all non-parity outputs.
   always_comb begin
      // NOTE: every signal written here gets a default first. Without the
      // defaults, a branch that skips an assignment would infer a latch.
      state_d            = state_q;
      cnt_d              = cnt_q;
      hold_d             = hold_q;
      in_ready           = 1'b0;
      sr_load_enable     = 1'b0;
      sr_serial_parallel = 1'b0;
      sr_parallel_in     = '0;
      sr_serial_in       = 1'b0;
      bit_valid          = 1'b0;
      bit_idx            = cnt_q;
      busy               = 1'b1;
      done               = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy     = 1'b0;
            // in_ready is masked by rst so it reads 0 while reset is held.
            in_ready = ~rst;
            if (in_valid) begin
               hold_d  = in_data;
               state_d = LOAD;
            end
         end

         LOAD: begin
            sr_load_enable     = 1'b1;
            sr_serial_parallel = 1'b1;
            sr_parallel_in     = hold_q;
            cnt_d              = '0;
            state_d            = SHIFT;
         end

         SHIFT: begin
            sr_serial_in = FILL;
            // While stalled the register and counter both hold, so the bit
            // on serial_out is presented again once stall drops.
            if (!stall) begin
               sr_load_enable = 1'b1;
               bit_valid      = 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = DONE;
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

`ifdef SHIFT_REG_CTRL_PARITY_EN
         PARITY: begin
            state_d = DONE;
         end
`endif

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef SHIFT_REG_CTRL_PARITY_EN
   // Parity slot: one cycle between the last data bit and DONE.
   always_comb begin
      parity_valid = (state_q == PARITY);
      parity_bit   = parity_valid & (^hold_q);
   end
`else
   assign parity_valid = 1'b0;
   assign parity_bit   = 1'b0;
`endif

endmodule
